// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter (ALU, load, link) with a registered write port and pending-write scoreboard
//   clk, rst                      : clock, synchronous active-high reset
//   alu_*/ld_*/lnk_*              : requesters 0/1/2 (valid/addr/data in, ready out); link always targets register 31
//   wb_stall                      : suppresses every grant while high
//   mark_valid, mark_addr         : set a register's pending bit
//   qry_addr_a/b -> busy_a/b      : combinational pending lookup with same-cycle write bypass
//   wr_en, wr_addr, wr_data       : registered register-file write port, one cycle after the grant
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              lnk_valid,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              alu_ready,
  output logic              ld_ready,
  output logic              lnk_ready,
  input  logic              wb_stall,
  input  logic              mark_valid,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] qry_addr_a,
  input  logic [ADDR_W-1:0] qry_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  localparam int NREG = 1 << ADDR_W;
  logic [1:0] ptr_q, ptr_d, p1, p2, sel;
  logic [3:0] v;
  logic [2:0] gnt;
  logic any;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0] pend_q, pend_d;
  // Search ptr, ptr+1, ptr+2 (mod 3); if the first two are idle and any is set, the third must be valid.
  always_comb begin
    v = {1'b0, lnk_valid, ld_valid, alu_valid};
    p1 = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
    p2 = ptr_q == 2'd0 ? 2'd2 : ptr_q - 2'd1;
    sel = v[ptr_q] ? ptr_q : v[p1] ? p1 : p2;
    any = !rst && !wb_stall && |v[2:0];
    gnt = any ? 3'b001 << sel : 3'b000;
    ptr_d = any ? (sel == 2'd2 ? 2'd0 : sel + 2'd1) : ptr_q;
    wr_en_d = any;
    wr_addr_d = !any ? wr_addr_q : sel == 2'd0 ? alu_addr : sel == 2'd1 ? ld_addr : {ADDR_W{1'b1}};
    wr_data_d = !any ? wr_data_q : sel == 2'd0 ? alu_data : sel == 2'd1 ? ld_data : lnk_data;
    pend_d = pend_q;
    if (wr_en_q) pend_d[wr_addr_q] = 1'b0;
    if (mark_valid) pend_d[mark_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pend_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pend_q <= pend_d;
    end
  end
  assign {lnk_ready, ld_ready, alu_ready} = gnt;
  // A write landing this cycle already retires the register for the hazard check.
  assign busy_a = pend_q[qry_addr_a] && !(wr_en_q && wr_addr_q == qry_addr_a);
  assign busy_b = pend_q[qry_addr_b] && !(wr_en_q && wr_addr_q == qry_addr_b);
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 5, register address width (32 registers).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: alu_valid, alu_addr, alu_data  input  1/ADDR_W/DATA_W  requester 0, ALU result writeback.
REQ-006 Port: ld_valid, ld_addr, ld_data  input  1/ADDR_W/DATA_W  requester 1, load-word writeback.
REQ-007 Port: lnk_valid, lnk_data  input  1/DATA_W  requester 2, branch-and-link return address; target register fixed at 31.
REQ-008 Port: alu_ready, ld_ready, lnk_ready  output  1 each  grant; a transfer occurs when valid and ready are both high.
REQ-009 Port: wb_stall  input  1  when high, no grant is issued.
REQ-010 Port: mark_valid, mark_addr  input  1/ADDR_W  issue stage marks a destination register as pending.
REQ-011 Port: qry_addr_a, qry_addr_b  input  ADDR_W each  hazard query addresses.
REQ-012 Port: busy_a, busy_b  output  1 each  queried register has a pending write (combinational).
REQ-013 Port: wr_en, wr_addr, wr_data  output  1/ADDR_W/DATA_W  registered write port to the register file.

Function
REQ-014 At most one ready SHALL be high per cycle; readies are combinational from valids, wb_stall and the priority pointer.
REQ-015 Arbitration SHALL be round-robin over requesters 0,1,2: search starts at ptr and wraps 2->0.
REQ-016 After a transfer from requester i, ptr SHALL become (i+1) mod 3; ptr is unchanged in cycles with no transfer.
REQ-017 Ready SHALL be asserted only to a requester whose valid is high; a requester SHALL hold valid/addr/data stable until ready.
REQ-018 With wb_stall high, all readies SHALL be 0, ptr held, and wr_en 0 next cycle.
REQ-019 Latency: a transfer in cycle N SHALL produce wr_en=1 with its addr/data in cycle N+1; requester 2 drives wr_addr=31.
REQ-020 With no transfer in cycle N, wr_en SHALL be 0 in N+1; wr_addr/wr_data hold their previous values.
REQ-021 Back-to-back transfers SHALL be sustained at one per cycle.
REQ-022 Scoreboard: 32 pending bits; mark_valid sets bit[mark_addr] at the clock edge.
REQ-023 The pending bit of a register SHALL clear at the edge where wr_en=1 for that wr_addr.
REQ-024 Simultaneous mark and clear of the same address SHALL leave the bit set (mark wins).
REQ-025 Marking an already-pending register SHALL leave it set; no count is kept.
REQ-026 Register 0 SHALL be treated as an ordinary register (no hard-wired zero).
REQ-027 busy_a/busy_b SHALL reflect the registered pending bit plus a bypass: 1 if the bit is set and no same-cycle wr_en clears that address, else 0.

Reset
REQ-028 While rst is high at a clock edge: ptr=0, wr_en=0, wr_addr=0, wr_data=0, all pending bits=0.
REQ-029 While rst is high, all readies SHALL be 0 and no transfer occurs; a grant in progress is dropped and the requester re-arbitrates after reset.
REQ-030 busy_a/busy_b SHALL be 0 in the first cycle after reset deasserts.

Verification
REQ-031 Single request: after reset, alu_valid=1, addr=7, data=0x1234 -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=7, wr_data=0x1234.
REQ-032 Round-robin: all three valid for 4 cycles -> grants ALU, LD, LNK, ALU; LNK write appears with wr_addr=31.
REQ-033 Stall: all valid, wb_stall=1 for 3 cycles -> no readies, wr_en=0; on release grant goes to the requester at ptr.
REQ-034 Scoreboard: mark addr 5 -> busy_a=1 for qry 5; ld writes addr 5 -> busy_a=0 in the wr_en cycle (bypass) and stays 0 afterwards; simultaneous mark 5 + write 5 -> bit stays set.
REQ-035 Reset mid-operation: ptr=2 with pending bits 3 and 9, assert rst one cycle -> ptr=0, busy 0 for all, wr_en=0; ALU wins first grant after release.
